cordic_tone_sched: RTL and testbench

Multi-channel tone scheduler that time-shares one cordicsine unit among NCH numerically-controlled oscillators. Per channel it keeps a phase accumulator and a phase step. On each sample tick it sequences the CORDIC once per enabled channel, in channel order, and emits one sine sample per channel. It sits between the sample-rate timebase/config bus and a single cordicsine instance in the parent.

---
 rtl/cordic_tone_sched_pkg.sv | 24 ++
 rtl/cordic_tone_sched_if.sv | 34 +++
 rtl/cordic_phase_acc.sv | 46 ++++
 rtl/cordic_tone_sched.sv | 104 ++++++++++
 tb/tb_cordic_tone_sched.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_tone_sched_pkg.sv
// Shared fixed-point constants and phase helpers for the CORDIC tone scheduler.
// Angles are unsigned 18-bit values with FIX_SHIFT fractional bits.
package cordic_tone_sched_pkg;
  localparam int          FIX_SHIFT  = 15;
  localparam logic [17:0] PI2        = 18'h0C90F;
  localparam logic [17:0] TWO_PI     = 18'h3243C;
  localparam logic [17:0] STEP_MAX   = 18'h1921D;
  localparam int          CORDIC_LAT = 19;

  typedef logic [17:0] phase_t;

  function automatic phase_t clamp_step(input phase_t s);
    return (s > STEP_MAX) ? STEP_MAX : s;
  endfunction

  // The sum can exceed 18 bits (phase just under 2*pi plus a max step), so add in 19.
  function automatic phase_t wrap_phase(input phase_t p, input phase_t s);
    logic [18:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    if (sum >= {1'b0, TWO_PI})
      sum = sum - {1'b0, TWO_PI};
    return sum[17:0];
  endfunction
endpackage

// File: rtl/cordic_tone_sched_if.sv
// Config, CORDIC-side and sample-output signals of the tone scheduler.
interface cordic_tone_sched_if #(parameter int CHW = 2);
  logic           sample_tick;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [17:0]    cfg_step;
  logic           cfg_en;
  logic           cfg_phase_clr;
  logic           clr_overrun;
  logic           cordic_update;
  logic [17:0]    cordic_angle;
  logic           cordic_ready;
  logic [15:0]    cordic_sine;
  logic           sample_valid;
  logic [CHW-1:0] sample_ch;
  logic [15:0]    sample_data;
  logic           frame_done;
  logic           busy;
  logic           overrun;

  modport slave (
    input  sample_tick, cfg_we, cfg_ch, cfg_step, cfg_en, cfg_phase_clr, clr_overrun,
           cordic_ready, cordic_sine,
    output cordic_update, cordic_angle, sample_valid, sample_ch, sample_data,
           frame_done, busy, overrun
  );

  modport master (
    output sample_tick, cfg_we, cfg_ch, cfg_step, cfg_en, cfg_phase_clr, clr_overrun,
           cordic_ready, cordic_sine,
    input  cordic_update, cordic_angle, sample_valid, sample_ch, sample_data,
           frame_done, busy, overrun
  );
endinterface

// File: rtl/cordic_phase_acc.sv
// Per-channel step/enable/phase registers: steps clamp on write, phases wrap on advance.
// A phase clear on the channel being advanced in the same cycle wins over the advance.
module cordic_phase_acc
  import cordic_tone_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  phase_t         cfg_step,
  input  logic           cfg_en,
  input  logic           cfg_phase_clr,
  input  logic           adv,
  input  logic [CHW-1:0] sel_ch,
  output phase_t         sel_phase,
  output logic           sel_en
);
  phase_t           steps [NCH];
  phase_t           phase [NCH];
  logic [NCH-1:0]   en;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        steps[i] <= '0;
        phase[i] <= '0;
      end
      en <= '0;
    end else begin
      if (adv)
        phase[sel_ch] <= wrap_phase(phase[sel_ch], steps[sel_ch]);
      if (cfg_we) begin
        steps[cfg_ch] <= clamp_step(cfg_step);
        en[cfg_ch]    <= cfg_en;
        if (cfg_phase_clr)
          phase[cfg_ch] <= '0;
      end
    end
  end

  assign sel_phase = phase[sel_ch];
  assign sel_en    = en[sel_ch];
endmodule

// File: rtl/cordic_tone_sched.sv
// Time-shares one cordicsine among NCH oscillators: per tick, one CORDIC pass per
// enabled channel in channel order, each producing a one-cycle sample pulse.
module cordic_tone_sched
  import cordic_tone_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic               clk,
  input  logic               reset,
  cordic_tone_sched_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SCAN    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_GUARD   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  logic [2:0]     state;
  logic [CHW-1:0] ch;
  logic [15:0]    cap_q;
  phase_t         angle_q;
  logic           overrun_q;
  phase_t         sel_phase;
  logic           sel_en;

  cordic_phase_acc #(.NCH(NCH), .CHW(CHW)) u_acc (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (bus.cfg_we),
    .cfg_ch        (bus.cfg_ch),
    .cfg_step      (bus.cfg_step),
    .cfg_en        (bus.cfg_en),
    .cfg_phase_clr (bus.cfg_phase_clr),
    .adv           (state == S_CAPTURE),
    .sel_ch        (ch),
    .sel_phase     (sel_phase),
    .sel_en        (sel_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ch        <= '0;
      cap_q     <= '0;
      angle_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      // A tick landing in FINISH is also dropped, since FINISH counts as busy.
      if (bus.sample_tick && (state != S_IDLE))
        overrun_q <= 1'b1;
      else if (bus.clr_overrun)
        overrun_q <= 1'b0;

      case (state)
        S_IDLE: if (bus.sample_tick) begin
          ch    <= '0;
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (sel_en)
            state <= S_ISSUE;
          else if (ch == LAST_CH)
            state <= S_FINISH;
          else
            ch <= ch + 1'b1;
        end
        S_ISSUE: begin
          angle_q <= sel_phase;
          state   <= S_GUARD;
        end
        // cordic_ready is still high from the previous DONE here.
        S_GUARD: state <= S_WAIT;
        S_WAIT: if (bus.cordic_ready) begin
          cap_q <= bus.cordic_sine;
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (ch == LAST_CH) begin
            state <= S_FINISH;
          end else begin
            ch    <= ch + 1'b1;
            state <= S_SCAN;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.cordic_update = (state == S_ISSUE);
  assign bus.cordic_angle  = angle_q;
  assign bus.sample_valid  = (state == S_CAPTURE);
  assign bus.sample_ch     = ch;
  assign bus.sample_data   = cap_q;
  assign bus.frame_done    = (state == S_FINISH);
  assign bus.busy          = (state != S_IDLE);
  assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_cordic_tone_sched.sv
// Directed bench for cordic_tone_sched with a behavioural 19-cycle cordicsine model.
module tb_cordic_tone_sched;
  import cordic_tone_sched_pkg::*;

  localparam int NCH = 4;
  localparam int CHW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cnt_c = 0;

  cordic_tone_sched_if #(.CHW(CHW)) bus ();

  cordic_tone_sched #(.NCH(NCH), .CHW(CHW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // cordicsine stand-in: INIT, 17 COMPUTE, DONE; ready stays high (stale) one cycle after update.
  always @(posedge clk) begin
    if (reset)
      cnt_c <= 0;
    else if (bus.cordic_update)
      cnt_c <= 1;
    else if (cnt_c != 0 && cnt_c < CORDIC_LAT)
      cnt_c <= cnt_c + 1;
  end

  function automatic logic [15:0] sine_model(input logic [17:0] a);
    real r;
    r = $sin(real'(a) / 32768.0) * 16384.0;
    return 16'($rtoi(r + ((r >= 0.0) ? 0.5 : -0.5)));
  endfunction

  assign bus.cordic_ready = (cnt_c == 0) || (cnt_c == 1) || (cnt_c == CORDIC_LAT);
  assign bus.cordic_sine  = sine_model(bus.cordic_angle);

  function automatic int sdiff(input logic [15:0] a, input int e);
    int d;
    d = int'($signed(a)) - e;
    return (d < 0) ? -d : d;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic pulse_tick();
    bus.sample_tick = 1'b1;
    cyc();
    bus.sample_tick = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input logic [17:0] step, input logic en, input logic clr);
    bus.cfg_we        = 1'b1;
    bus.cfg_ch        = CHW'(ch);
    bus.cfg_step      = step;
    bus.cfg_en        = en;
    bus.cfg_phase_clr = clr;
    cyc();
    bus.cfg_we        = 1'b0;
    bus.cfg_phase_clr = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (n < maxc) begin
      if (bus.sample_valid) begin
        got = 1'b1;
        break;
      end
      cyc();
      n++;
    end
  endtask

  task automatic wait_done(input int maxc, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (n < maxc) begin
      if (bus.frame_done) begin
        got = 1'b1;
        break;
      end
      cyc();
      n++;
    end
  endtask

  task automatic wait_update(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (bus.cordic_update) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    logic [40:0] outs;
    do_reset();
    outs = {bus.sample_valid, bus.sample_ch, bus.sample_data, bus.frame_done, bus.busy,
            bus.overrun, bus.cordic_update, bus.cordic_angle};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
  endtask

  task automatic test_no_channels();
    int nv = 0;
    int n = 0;
    bit got = 1'b0;
    do_reset();
    pulse_tick();
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_busy: got %b want 1", bus.busy);
    end
    while (n < 20) begin
      if (bus.sample_valid) nv++;
      if (bus.frame_done) begin
        got = 1'b1;
        break;
      end
      cyc();
      n++;
    end
    // tick cycle + NCH scan cycles, then FINISH
    n_tests++;
    if (!got || n != NCH) begin
      n_fail++;
      $display("FAIL empty_done_latency: got %0d (seen %0b) want %0d", n + 1, got, NCH + 1);
    end
    n_tests++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL empty_samples: got %0d want 0", nv);
    end
    cyc();
  endtask

  task automatic test_single_sine();
    int  exp_s [5] = '{0, 16384, 0, -16384, 0};
    bit  got;
    int  n;
    do_reset();
    cfg_write(0, PI2, 1'b1, 1'b0);
    for (int f = 0; f < 5; f++) begin
      pulse_tick();
      wait_valid(60, got, n);
      if (f == 0) begin
        // SCAN, ISSUE, then 20 cycles to CAPTURE
        n_tests++;
        if (!got || n != 21) begin
          n_fail++;
          $display("FAIL sine_latency: got %0d (seen %0b) want 21", n, got);
        end
      end
      n_tests++;
      if (!got || bus.sample_ch !== 2'd0 || sdiff(bus.sample_data, exp_s[f]) > 8) begin
        n_fail++;
        $display("FAIL sine_frame%0d: got ch %0d data %0d want ch 0 data %0d+-8",
                 f, bus.sample_ch, $signed(bus.sample_data), exp_s[f]);
      end
      wait_done(20, got, n);
      // ch1..ch3 are scanned after the ch0 capture before FINISH
      n_tests++;
      if (!got || n != 4) begin
        n_fail++;
        $display("FAIL sine_done%0d: got %0d cycles after sample want 4", f, n);
      end
      cyc();
    end
  endtask

  task automatic test_step_clamp();
    bit got;
    int n;
    do_reset();
    cfg_write(0, 18'h30000, 1'b1, 1'b0);
    // phases 0, 0x1921D, 0x3243A, 0x1921B: all within a few LSB of a zero crossing
    for (int f = 0; f < 4; f++) begin
      pulse_tick();
      wait_valid(60, got, n);
      n_tests++;
      if (!got || sdiff(bus.sample_data, 0) > 8) begin
        n_fail++;
        $display("FAIL clamp_frame%0d: got %0d want 0+-8", f, $signed(bus.sample_data));
      end
      wait_done(20, got, n);
      cyc();
    end
  endtask

  task automatic test_two_channels();
    int  exp0 [2] = '{0, 16384};
    int  exp2 [2] = '{0, 11585};
    bit  got;
    int  n;
    do_reset();
    cfg_write(0, PI2, 1'b1, 1'b0);
    cfg_write(2, 18'h06487, 1'b1, 1'b0);
    for (int f = 0; f < 2; f++) begin
      pulse_tick();
      wait_valid(60, got, n);
      n_tests++;
      if (!got || bus.sample_ch !== 2'd0 || sdiff(bus.sample_data, exp0[f]) > 8) begin
        n_fail++;
        $display("FAIL two_ch0_f%0d: got ch %0d data %0d want ch 0 data %0d+-8",
                 f, bus.sample_ch, $signed(bus.sample_data), exp0[f]);
      end
      cyc();
      wait_valid(60, got, n);
      // disabled ch1 costs one extra SCAN cycle: 22 + 1
      n_tests++;
      if (!got || bus.sample_ch !== 2'd2 || n + 1 != 23 || sdiff(bus.sample_data, exp2[f]) > 8) begin
        n_fail++;
        $display("FAIL two_ch2_f%0d: got ch %0d gap %0d data %0d want ch 2 gap 23 data %0d+-8",
                 f, bus.sample_ch, n + 1, $signed(bus.sample_data), exp2[f]);
      end
      wait_done(20, got, n);
      n_tests++;
      if (!got || n != 2) begin
        n_fail++;
        $display("FAIL two_done_f%0d: got %0d want 2", f, n);
      end
      cyc();
    end
    cfg_write(1, 18'h0, 1'b1, 1'b0);
    pulse_tick();
    wait_valid(60, got, n);
    for (int c = 1; c < 3; c++) begin
      cyc();
      wait_valid(60, got, n);
      n_tests++;
      if (!got || bus.sample_ch !== CHW'(c) || n + 1 != 22) begin
        n_fail++;
        $display("FAIL b2b_ch%0d: got ch %0d gap %0d want ch %0d gap 22", c, bus.sample_ch, n + 1, c);
      end
    end
    wait_done(20, got, n);
    cyc();
  endtask

  task automatic test_overrun();
    int nv = 0;
    int nb = 0;
    int n = 0;
    bit got = 1'b0;
    do_reset();
    cfg_write(0, 18'h0, 1'b1, 1'b0);
    pulse_tick();
    repeat (4) cyc();
    pulse_tick();
    n_tests++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b want 1", bus.overrun);
    end
    while (n < 80) begin
      if (bus.sample_valid) nv++;
      if (bus.frame_done) begin
        got = 1'b1;
        break;
      end
      cyc();
      n++;
    end
    n_tests++;
    if (!got || nv != 1) begin
      n_fail++;
      $display("FAIL overrun_frame: got %0d samples (done %0b) want 1", nv, got);
    end
    cyc();
    for (int i = 0; i < 40; i++) begin
      if (bus.busy || bus.sample_valid) nb++;
      cyc();
    end
    n_tests++;
    if (nb != 0) begin
      n_fail++;
      $display("FAIL overrun_extra_frame: got %0d busy cycles want 0", nb);
    end
    bus.clr_overrun = 1'b1;
    cyc();
    bus.clr_overrun = 1'b0;
    n_tests++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b want 0", bus.overrun);
    end
    pulse_tick();
    bus.sample_tick = 1'b1;
    bus.clr_overrun = 1'b1;
    cyc();
    bus.sample_tick = 1'b0;
    bus.clr_overrun = 1'b0;
    n_tests++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set_wins: got %b want 1", bus.overrun);
    end
    wait_done(80, got, n);
    cyc();
    bus.clr_overrun = 1'b1;
    cyc();
    bus.clr_overrun = 1'b0;
    pulse_tick();
    wait_done(80, got, n);
    bus.sample_tick = 1'b1;
    cyc();
    bus.sample_tick = 1'b0;
    n_tests++;
    if (!got || bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_finish_tick: got overrun %b busy %b want 1 0", bus.overrun, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [40:0] outs;
    bit got;
    int n;
    do_reset();
    cfg_write(0, PI2, 1'b1, 1'b0);
    pulse_tick();
    wait_done(80, got, n);
    cyc();
    pulse_tick();
    wait_update(20, got);
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    outs = {bus.sample_valid, bus.sample_ch, bus.sample_data, bus.frame_done, bus.busy,
            bus.overrun, bus.cordic_update, bus.cordic_angle};
    n_tests++;
    if (!got || outs !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h (issued %0b) want 0", outs, got);
    end
    reset = 1'b0;
    cyc();
    cfg_write(0, PI2, 1'b1, 1'b0);
    pulse_tick();
    wait_valid(60, got, n);
    n_tests++;
    if (!got || bus.sample_ch !== 2'd0 || sdiff(bus.sample_data, 0) > 8) begin
      n_fail++;
      $display("FAIL midreset_restart: got ch %0d data %0d want ch 0 data 0+-8",
               bus.sample_ch, $signed(bus.sample_data));
    end
    wait_done(20, got, n);
    cyc();
  endtask

  task automatic test_clr_vs_capture();
    bit got;
    int n;
    do_reset();
    cfg_write(0, PI2, 1'b1, 1'b0);
    pulse_tick();
    wait_update(20, got);
    repeat (20) cyc();
    n_tests++;
    if (!got || bus.sample_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_capture_align: got valid %b want 1", bus.sample_valid);
    end
    cfg_write(0, PI2, 1'b1, 1'b1);
    wait_done(20, got, n);
    cyc();
    for (int f = 0; f < 2; f++) begin
      pulse_tick();
      wait_valid(60, got, n);
      n_tests++;
      if (!got || sdiff(bus.sample_data, (f == 0) ? 0 : 16384) > 8) begin
        n_fail++;
        $display("FAIL clr_wins_f%0d: got %0d want %0d+-8", f, $signed(bus.sample_data),
                 (f == 0) ? 0 : 16384);
      end
      wait_done(20, got, n);
      cyc();
    end
  endtask

  initial begin
    bus.sample_tick   = 1'b0;
    bus.cfg_we        = 1'b0;
    bus.cfg_ch        = '0;
    bus.cfg_step      = '0;
    bus.cfg_en        = 1'b0;
    bus.cfg_phase_clr = 1'b0;
    bus.clr_overrun   = 1'b0;
    test_reset();
    test_no_channels();
    test_single_sine();
    test_step_clamp();
    test_two_channels();
    test_overrun();
    test_reset_mid();
    test_clr_vs_capture();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
